wb_rr_arbiter: RTL and testbench

- Wishbone Classic round-robin arbiter that lets NM masters share one Wishbone slave port, for example the PID controller register port (kp/ki/kd/sv).
- Typical masters are a host CPU, an auto-tuner and a debug bridge.
- The arbiter holds a grant for the whole master cycle (cyc asserted), so SINGLE and BLOCK cycles are never interleaved.
- A per-transfer watchdog terminates a stalled slave access with an error, so one hung slave cannot lock the bus.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_rr_arbiter_if.sv | 34 +++
 rtl/rr_pick.sv | 33 +++
 rtl/wb_rr_arbiter.sv | 118 +++++++++++
 tb/tb_wb_rr_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone constants, arbiter state encoding and a constant clog2 helper.
package wb_pkg;

`ifdef wb_16bit
    localparam int WB_NB = 16;
`elsif wb_64bit
    localparam int WB_NB = 64;
`else
    localparam int WB_NB = 32;
`endif
    localparam int ADR_WB_NB = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        ERR  = ST_ERR
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Master-side and slave-side Wishbone signals of the round-robin arbiter.
interface wb_rr_arbiter_if import wb_pkg::*; #(
    parameter int NM        = 4,
    parameter int wb_nb     = WB_NB,
    parameter int adr_wb_nb = ADR_WB_NB
);
    logic [NM-1:0]           i_m_cyc;
    logic [NM-1:0]           i_m_stb;
    logic [NM-1:0]           i_m_we;
    logic [NM*adr_wb_nb-1:0] i_m_adr;
    logic [NM*wb_nb-1:0]     i_m_data;
    logic [NM-1:0]           o_m_ack;
    logic [NM-1:0]           o_m_err;
    logic [wb_nb-1:0]        o_m_data;
    logic                    o_s_cyc;
    logic                    o_s_stb;
    logic                    o_s_we;
    logic [adr_wb_nb-1:0]    o_s_adr;
    logic [wb_nb-1:0]        o_s_data;
    logic                    i_s_ack;
    logic [wb_nb-1:0]        i_s_data;
    logic [NM-1:0]           o_gnt;

    // The arbiter itself is the slave of the masters' requests.
    modport slave (
        input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_data, i_s_ack, i_s_data,
        output o_m_ack, o_m_err, o_m_data, o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_data, o_gnt
    );

    modport master (
        output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_data, i_s_ack, i_s_data,
        input  o_m_ack, o_m_err, o_m_data, o_s_cyc, o_s_stb, o_s_we, o_s_adr, o_s_data, o_gnt
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester above 'last', wrapping to 0.
module rr_pick import wb_pkg::*; #(
    parameter int NM = 4,
    parameter int IW = (NM > 1) ? clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx
);
    logic [NM-1:0] mask;
    logic [NM-1:0] masked;
    logic [NM-1:0] pool;

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_mask
            assign mask[gi] = (IW'(gi) > last);
        end
    endgenerate

    // Prefer requesters above 'last'; if none, fall back to the lowest overall.
    assign masked = req & mask;
    assign pool   = (|masked) ? masked : req;
    assign gnt    = pool & (~pool + NM'(1));

    always_comb begin
        idx = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone Classic round-robin arbiter: holds the grant for a whole master cycle
// and aborts a stalled slave access with err after TIMEOUT cycles.
module wb_rr_arbiter import wb_pkg::*; #(
    parameter int NM        = 4,
    parameter int wb_nb     = WB_NB,
    parameter int adr_wb_nb = ADR_WB_NB,
    parameter int TIMEOUT   = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    wb_rr_arbiter_if.slave  bus
);
    localparam int IW = (NM > 1) ? clog2(NM) : 1;
    localparam int CW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_reg;
    logic [NM-1:0]    gnt_reg;
    logic [IW-1:0]    last_reg;
    logic [CW-1:0]    wd_reg;
    logic [NM-1:0]    pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             busy;
    logic             in_err;
    logic             wd_fire;
    logic             sel_cyc;
    logic             sel_stb;
    logic             sel_we;
    logic [adr_wb_nb-1:0] sel_adr;
    logic [wb_nb-1:0]     sel_data;

    rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .req  (bus.i_m_cyc),
        .last (last_reg),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // One-hot AND-OR mux; gnt_reg is zero in IDLE so nothing leaks through.
    always_comb begin
        sel_cyc  = 1'b0;
        sel_stb  = 1'b0;
        sel_we   = 1'b0;
        sel_adr  = '0;
        sel_data = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_reg[i]) begin
                sel_cyc  = sel_cyc | bus.i_m_cyc[i];
                sel_stb  = sel_stb | bus.i_m_stb[i];
                sel_we   = sel_we  | bus.i_m_we[i];
                sel_adr  = sel_adr  | bus.i_m_adr[i*adr_wb_nb +: adr_wb_nb];
                sel_data = sel_data | bus.i_m_data[i*wb_nb +: wb_nb];
            end
        end
    end

    assign busy    = (state_reg == BUSY);
    assign in_err  = (state_reg == ERR);
    assign wd_fire = (TIMEOUT > 0) && busy && sel_stb && !bus.i_s_ack && (wd_reg == WD_LAST);

    assign bus.o_s_cyc  = busy & sel_cyc;
    assign bus.o_s_stb  = busy & sel_stb;
    assign bus.o_s_we   = sel_we;
    assign bus.o_s_adr  = sel_adr;
    assign bus.o_s_data = sel_data;
    assign bus.o_m_data = bus.i_s_data;
    assign bus.o_m_ack  = busy   ? (gnt_reg & bus.i_m_stb & {NM{bus.i_s_ack}}) : '0;
    assign bus.o_m_err  = in_err ? (gnt_reg & bus.i_m_stb) : '0;
    assign bus.o_gnt    = gnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            last_reg  <= IW'(NM - 1);
            wd_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wd_reg <= '0;
                    if (|bus.i_m_cyc) begin
                        gnt_reg   <= pick_gnt;
                        last_reg  <= pick_idx;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (!sel_cyc) begin
                        gnt_reg   <= '0;
                        wd_reg    <= '0;
                        state_reg <= IDLE;
                    end else if (wd_fire) begin
                        wd_reg    <= '0;
                        state_reg <= ERR;
                    end else if ((TIMEOUT > 0) && sel_stb && !bus.i_s_ack) begin
                        wd_reg <= wd_reg + CW'(1);
                    end else begin
                        wd_reg <= '0;
                    end
                end
                ERR: begin
                    wd_reg <= '0;
                    if (!sel_cyc) begin
                        gnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (!sel_stb) begin
                        state_reg <= BUSY;
                    end
                end
                default: begin
                    gnt_reg   <= '0;
                    wd_reg    <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: vector table for grant rotation, hand sequences
// for block transfers, watchdog timing, ack/timeout race and mid-transfer reset.
module tb_wb_rr_arbiter;
    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NM(NM), .wb_nb(DW), .adr_wb_nb(AW)) bus ();

    wb_rr_arbiter #(.NM(NM), .wb_nb(DW), .adr_wb_nb(AW), .TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  cyc, stb, we;
        logic        ack;
        logic [3:0]  e_gnt;
        logic        e_cyc, e_stb, e_we;
        logic [3:0]  e_ack, e_err;
        logic [15:0] e_adr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic void add(input logic r, input logic [3:0] c, input logic [3:0] s,
                                input logic [3:0] w, input logic a, input logic [3:0] g,
                                input logic ec, input logic es, input logic ew,
                                input logic [3:0] ek, input logic [3:0] ee,
                                input logic [15:0] ad, input logic [31:0] d);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.ack = a;
        v.e_gnt = g; v.e_cyc = ec; v.e_stb = es; v.e_we = ew;
        v.e_ack = ek; v.e_err = ee; v.e_adr = ad; v.e_data = d;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_adr(input int k, input logic [15:0] a);
        bus.i_m_adr[k*AW +: AW] = a;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500us");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] all1;
        logic [3:0] cyc_k;
        logic [3:0] cyc_n;
        logic [3:0] g;
        all1 = 4'hF;

        bus.i_m_cyc = '0; bus.i_m_stb = '0; bus.i_m_we = '0;
        bus.i_s_ack = 1'b0; bus.i_s_data = '0;
        for (int k = 0; k < NM; k++) begin
            bus.i_m_adr[k*AW +: AW]  = 16'(k * 4);
            bus.i_m_data[k*DW +: DW] = 32'h1234 * k;
        end

        // Single write by master 1, then ack outside BUSY is ignored.
        add(0, 4'b0010, 4'b0010, 4'b0010, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 16'h0, 32'h0);
        add(0, 4'b0010, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1, 4'b0000, 4'b0000, 16'h4, 32'h1234);
        add(0, 4'b0010, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1, 4'b0010, 4'b0000, 16'h4, 32'h1234);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 16'h4, 32'h1234);
        add(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 16'h0, 32'h0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 16'h0, 32'h0);
        // All four request: idle row, granted ack row, drop row; twice round.
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < NM; k++) begin
                cyc_k = all1 << k;
                cyc_n = all1 << (k + 1);
                g = 4'b0001 << k;
                add(0, cyc_k, cyc_k, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 16'h0, 32'h0);
                add(0, cyc_k, cyc_k, 4'b0000, 1, g, 1, 1, 0, g, 4'b0000, 16'(k * 4), 32'h1234 * k);
                add(0, cyc_n, cyc_n, 4'b0000, 0, g, 0, 0, 0, 4'b0000, 4'b0000, 16'(k * 4), 32'h1234 * k);
            end
        end

        repeat (3) @(posedge clk);
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst;
            bus.i_m_cyc = vecs[i].cyc;
            bus.i_m_stb = vecs[i].stb;
            bus.i_m_we  = vecs[i].we;
            bus.i_s_ack = vecs[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  128'({bus.o_gnt, bus.o_s_cyc, bus.o_s_stb, bus.o_s_we, bus.o_m_ack,
                        bus.o_m_err, bus.o_s_adr, bus.o_s_data}),
                  128'({vecs[i].e_gnt, vecs[i].e_cyc, vecs[i].e_stb, vecs[i].e_we, vecs[i].e_ack,
                        vecs[i].e_err, vecs[i].e_adr, vecs[i].e_data}));
            $display("vec %0d rst=%b cyc=%b ack=%b -> gnt=%b m_ack=%b s_cyc=%b",
                     i, rst, bus.i_m_cyc, bus.i_s_ack, bus.o_gnt, bus.o_m_ack, bus.o_s_cyc);
        end

        // Block read by master 2 while master 0 waits.
        step();
        set_adr(2, 16'h0);
        bus.i_m_cyc = 4'b0100; bus.i_m_stb = 4'b0100; bus.i_m_we = 4'b0000;
        step();
        bus.i_m_cyc = 4'b0101; bus.i_m_stb = 4'b0101;
        for (int w = 0; w < 4; w++) begin
            set_adr(2, 16'(w * 4));
            bus.i_s_ack = 1'b1;
            bus.i_s_data = 32'hD000_0000 + 32'(w);
            sample();
            check($sformatf("blk%0d", w),
                  128'({bus.o_gnt, bus.o_s_adr, bus.o_m_data, bus.o_m_ack}),
                  128'({4'b0100, 16'(w * 4), 32'hD000_0000 + 32'(w), 4'b0100}));
            $display("blk word %0d adr=%h data=%h", w, bus.o_s_adr, bus.o_m_data);
            step();
        end
        bus.i_s_ack = 1'b0;
        bus.i_m_cyc = 4'b0001; bus.i_m_stb = 4'b0001;
        sample();
        check("blk_hold", 128'({bus.o_gnt, bus.o_m_ack}), 128'({4'b0100, 4'b0000}));
        step();
        sample();
        check("blk_idle", 128'(bus.o_gnt), 128'(4'b0000));
        step();
        sample();
        check("blk_next", 128'(bus.o_gnt), 128'(4'b0001));
        bus.i_m_cyc = '0; bus.i_m_stb = '0;
        step();

        // Watchdog: slave never acks master 3; master 1 waits behind it.
        bus.i_m_cyc = 4'b1000; bus.i_m_stb = 4'b1000;
        step();
        bus.i_m_cyc = 4'b1010; bus.i_m_stb = 4'b1010;
        for (int c = 0; c < TO; c++) begin
            sample();
            check($sformatf("wd_wait%0d", c), 128'({bus.o_m_err, bus.o_s_stb}), 128'({4'b0000, 1'b1}));
            step();
        end
        sample();
        check("wd_err", 128'({bus.o_m_err, bus.o_s_cyc, bus.o_gnt}), 128'({4'b1000, 1'b0, 4'b1000}));
        $display("watchdog err=%b s_cyc=%b", bus.o_m_err, bus.o_s_cyc);
        bus.i_m_cyc = 4'b0010; bus.i_m_stb = 4'b0010;
        step();
        sample();
        check("wd_idle", 128'({bus.o_gnt, bus.o_m_err}), 128'({4'b0000, 4'b0000}));
        step();
        sample();
        check("wd_next", 128'(bus.o_gnt), 128'(4'b0010));
        bus.i_m_cyc = '0; bus.i_m_stb = '0;
        step();

        // Ack lands on the last counted cycle: ack wins, no err.
        bus.i_m_cyc = 4'b0100; bus.i_m_stb = 4'b0100;
        step();
        for (int c = 0; c < TO - 1; c++) begin
            sample();
            check($sformatf("race_wait%0d", c), 128'(bus.o_m_err), 128'(4'b0000));
            step();
        end
        bus.i_s_ack = 1'b1;
        sample();
        check("race_ack", 128'({bus.o_m_ack, bus.o_m_err}), 128'({4'b0100, 4'b0000}));
        step();
        bus.i_s_ack = 1'b0;
        sample();
        check("race_after", 128'({bus.o_m_err, bus.o_s_stb, bus.o_gnt}), 128'({4'b0000, 1'b1, 4'b0100}));
        $display("race ack err=%b stb=%b", bus.o_m_err, bus.o_s_stb);
        bus.i_m_cyc = '0; bus.i_m_stb = '0;
        step();

        // Reset in the middle of master 1's block cycle.
        bus.i_m_cyc = 4'b0010; bus.i_m_stb = 4'b0010;
        step();
        bus.i_s_ack = 1'b1;
        sample();
        check("rst_pre_ack", 128'(bus.o_m_ack), 128'(4'b0010));
        step();
        bus.i_s_ack = 1'b0;
        rst = 1'b1;
        sample();
        check("rst_pre_gnt", 128'(bus.o_gnt), 128'(4'b0010));
        step();
        rst = 1'b0;
        // Master 2 also requests: a stale last pointer (1) would pick 2, a reset one (3) picks 0.
        bus.i_m_cyc = 4'b0111; bus.i_m_stb = 4'b0111;
        sample();
        check("rst_drop", 128'({bus.o_gnt, bus.o_s_cyc, bus.o_m_ack}), 128'({4'b0000, 1'b0, 4'b0000}));
        step();
        sample();
        check("rst_first", 128'(bus.o_gnt), 128'(4'b0001));
        $display("after reset gnt=%b", bus.o_gnt);
        bus.i_m_cyc = '0; bus.i_m_stb = '0;
        step();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
